// File: rtl/sdn_parser_action_loader.sv
// -----------------------------------------------------------------------------
// sdn_parser_action_loader
//
// Loads action-table entries into a parser action RAM from a word-wide
// configuration stream.  A command is one header word followed by N entries of
// BEATS = DATA_W/WORD_W data words each.  Words arrive least-significant first.
// Each complete entry is written to the RAM with a single-cycle write strobe.
//
// Header word layout:
//   s_data_i[ADDR_W-1:0]          start address of the first entry
//   s_data_i[WORD_W-1:WORD_W/2]   entry count N (N = 0 is an empty command)
//
// Optional feature (compile-time macro):
//   SDN_ACTION_LOADER_LAST_CHK_EN  enables s_last_i framing checks.  When it is
//                                  undefined, framing is by N alone, s_last_i
//                                  is ignored, DRAIN is unreachable and err_o
//                                  is tied to 0.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   resetn       synchronous active-low reset
//   s_valid_i    config word valid
//   s_ready_o    block accepts a word (low only while an entry is written)
//   s_data_i     config word: header or data beat
//   s_last_i     final word of a command
//   en_a_o       one-cycle RAM write enable
//   wraddr_a_o   RAM write address (holds between writes)
//   wrdata_a_o   RAM write data (holds between writes)
//   busy_o       high whenever the FSM is not idle
//   done_o       one-cycle pulse at command completion
//   err_o        sticky framing-error flag, cleared by the next good header
//   wr_count_o   entries written by the current command
// -----------------------------------------------------------------------------
module sdn_parser_action_loader #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              en_a_o,
  output logic [ADDR_W-1:0] wraddr_a_o,
  output logic [DATA_W-1:0] wrdata_a_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   wr_count_o
);

  localparam int BEATS  = DATA_W / WORD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = WORD_W - WORD_W / 2;

`ifdef SDN_ACTION_LOADER_LAST_CHK_EN
  localparam bit LAST_CHK_EN = 1'b1;
`else
  localparam bit LAST_CHK_EN = 1'b0;
`endif

  // Parameter sanity: the entry must be a whole number of words and the start
  // address must fit in the lower half of the header word.
  if (DATA_W % WORD_W != 0) begin : g_bad_data_w
    $error("DATA_W must be an integer multiple of WORD_W");
  end
  if (ADDR_W > WORD_W / 2) begin : g_bad_addr_w
    $error("ADDR_W must not exceed WORD_W/2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // await header
    ST_DATA  = 2'd1,  // collect beats of an entry
    ST_WRITE = 2'd2,  // write strobe cycle for the assembled entry
    ST_DRAIN = 2'd3   // discard words until s_last_i
  } state_t;

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [CNT_W-1:0]    entries_left_q;
  logic                drain_q;        // enter DRAIN after the current write
  logic [DATA_W-1:0]   entry_q;        // entry assembly buffer
  logic [DATA_W-1:0]   entry_next;

  logic                xfer;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [CNT_W-1:0]    hdr_count;
  logic                final_beat;
  logic                last_entry;

  // Decoded actions for the current cycle
  logic                hdr_load;
  logic                beat_store;
  logic                beat_write;
  logic                zero_done;
  logic                miss_last;
  logic                err_set;
  logic                err_clr;

  assign xfer       = s_valid_i & s_ready_o;
  assign hdr_addr   = s_data_i[ADDR_W-1:0];
  assign hdr_count  = s_data_i[WORD_W-1:WORD_W/2];
  assign final_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_entry = (entries_left_q == CNT_W'(1));

  // The incoming beat merged into its slot.  Every slot is overwritten before
  // the final beat, so stale words from an aborted entry never reach the RAM.
  always_comb begin
    entry_next = entry_q;
    entry_next[beat_q * WORD_W +: WORD_W] = s_data_i;
  end

  // Next-state and action decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned and no latch is inferred.
    state_n    = state_q;
    hdr_load   = 1'b0;
    beat_store = 1'b0;
    beat_write = 1'b0;
    zero_done  = 1'b0;
    miss_last  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (hdr_count == '0) begin
            // Empty command: no write, completion reported next cycle.
            if (LAST_CHK_EN && !s_last_i) begin
              err_set = 1'b1;
              state_n = ST_DRAIN;
            end else begin
              zero_done = 1'b1;
            end
          end else if (LAST_CHK_EN && s_last_i) begin
            // Command ends on its own header: nothing to collect.
            err_set = 1'b1;
          end else begin
            hdr_load = 1'b1;
            err_clr  = 1'b1;
            state_n  = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (xfer) begin
          if (LAST_CHK_EN && s_last_i && !(final_beat && last_entry)) begin
            // Early end of command: drop the entry being assembled.
            err_set = 1'b1;
            state_n = ST_IDLE;
          end else if (final_beat) begin
            beat_write = 1'b1;
            state_n    = ST_WRITE;
            if (LAST_CHK_EN && last_entry && !s_last_i) begin
              // Last entry is still written; the rest of the command is junk.
              err_set   = 1'b1;
              miss_last = 1'b1;
            end
          end else begin
            beat_store = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (!last_entry) begin
          state_n = ST_DATA;
        end else if (drain_q) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (xfer && s_last_i) begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      busy_o         <= 1'b0;
      s_ready_o      <= 1'b0;
      en_a_o         <= 1'b0;
      done_o         <= 1'b0;
      wraddr_a_o     <= '0;
      wrdata_a_o     <= '0;
      wr_count_o     <= '0;
      addr_q         <= '0;
      beat_q         <= '0;
      entries_left_q <= '0;
      drain_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_n;
      busy_o    <= (state_n != ST_IDLE);
      s_ready_o <= (state_n != ST_WRITE);
      en_a_o    <= beat_write;
      done_o    <= zero_done | (beat_write & last_entry & ~miss_last);

      if (hdr_load) begin
        addr_q         <= hdr_addr;
        wr_count_o     <= '0;
        entries_left_q <= hdr_count;
      end

      if (hdr_load || beat_write) begin
        beat_q <= '0;
      end else if (beat_store) begin
        beat_q <= beat_q + BEAT_W'(1);
      end

      if (beat_write) begin
        wraddr_a_o <= addr_q;
        wrdata_a_o <= entry_next;
        drain_q    <= miss_last;
      end

      // Leaving WRITE: advance to the next entry slot (wraps naturally).
      if (state_q == ST_WRITE) begin
        addr_q         <= addr_q + ADDR_W'(1);
        wr_count_o     <= wr_count_o + (ADDR_W + 1)'(1);
        entries_left_q <= entries_left_q - CNT_W'(1);
      end
    end
  end

  // NOTE: the assembly buffer is datapath storage and is deliberately not
  // reset; control state guarantees it is fully rewritten before any use.
  always_ff @(posedge clk) begin
    if (beat_store) begin
      entry_q <= entry_next;
    end
  end

`ifdef SDN_ACTION_LOADER_LAST_CHK_EN
  // Sticky framing error; a new error takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end else if (err_clr) begin
      err_o <= 1'b0;
    end
  end
`else
  assign err_o = 1'b0;

  logic unused_err_flags;
  assign unused_err_flags = err_set ^ err_clr;
`endif

endmodule
